// File: rtl/lsu_dcache_port.sv
// Load/store unit port to a word-organised data cache: aligns stores into byte lanes,
// formats loads, flags misaligned/illegal requests and bounds the wait for the cache.
module lsu_dcache_port #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [1:0]              req_size_i,
  input  logic                    req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  output logic                    resp_valid_o,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    resp_err_o,
  output logic [1:0]              resp_cause_o,
  output logic [ADDR_WIDTH-1:0]   cache_addr_o,
  output logic [DATA_WIDTH-1:0]   cache_wdata_o,
  output logic [DATA_WIDTH/8-1:0] cache_wstrb_o,
  output logic                    cache_write_o,
  output logic                    cache_read_o,
  input  logic [DATA_WIDTH-1:0]   cache_rdata_i,
  input  logic                    cache_ready_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] CAUSE_OK      = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              size_q;
  logic                    we_q;
  logic                    uns_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [1:0]              cause_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [CNT_W-1:0]        cnt_q;

  logic                    req_illegal;
  logic                    req_misalign;
  logic                    timeout_hit;
  logic [DATA_WIDTH-1:0]   load_lane;
  logic [DATA_WIDTH-1:0]   load_fmt;

  assign req_illegal  = (req_size_i == 2'b11);
  assign req_misalign = ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
                        ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
  assign timeout_hit  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Readiness is also gated by rst_n so the core sees "not ready" while reset is held.
  assign req_ready_o  = rst_n && (state_q == S_IDLE);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = (req_illegal || req_misalign) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (cache_ready_i || timeout_hit) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    load_lane = cache_rdata_i >> {addr_q[1:0], 3'b000};
    load_fmt  = load_lane;
    case (size_q)
      SZ_BYTE: load_fmt = uns_q ? {{(DATA_WIDTH-8){1'b0}}, load_lane[7:0]}
                                : {{(DATA_WIDTH-8){load_lane[7]}}, load_lane[7:0]};
      SZ_HALF: load_fmt = uns_q ? {{(DATA_WIDTH-16){1'b0}}, load_lane[15:0]}
                                : {{(DATA_WIDTH-16){load_lane[15]}}, load_lane[15:0]};
      default: load_fmt = load_lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      cause_q <= CAUSE_OK;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            size_q  <= req_size_i;
            we_q    <= req_we_i;
            uns_q   <= req_unsigned_i;
            wdata_q <= req_wdata_i;
            if (req_illegal) begin
              cause_q <= CAUSE_ILLEGAL;
              rdata_q <= '0;
            end else if (req_misalign) begin
              cause_q <= CAUSE_MISALIGN;
              rdata_q <= '0;
            end else begin
              cause_q <= CAUSE_OK;
            end
          end
        end
        S_ISSUE: cnt_q <= '0;
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cache_ready_i) begin
            cause_q <= CAUSE_OK;
            rdata_q <= we_q ? '0 : load_fmt;
          end else if (timeout_hit) begin
            cause_q <= CAUSE_TIMEOUT;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Store data is replicated across lanes; the strobe selects which lanes the cache writes.
  always_comb begin
    cache_wdata_o = '0;
    cache_wstrb_o = '0;
    if ((state_q == S_ISSUE) && we_q) begin
      case (size_q)
        SZ_BYTE: begin
          cache_wdata_o = {4{wdata_q[7:0]}};
          cache_wstrb_o = 4'b0001 << addr_q[1:0];
        end
        SZ_HALF: begin
          cache_wdata_o = {2{wdata_q[15:0]}};
          cache_wstrb_o = 4'b0011 << addr_q[1:0];
        end
        default: begin
          cache_wdata_o = wdata_q;
          cache_wstrb_o = 4'b1111;
        end
      endcase
    end
  end

  assign cache_write_o = (state_q == S_ISSUE) && we_q;
  assign cache_read_o  = (state_q == S_ISSUE) && !we_q;
  assign cache_addr_o  = ((state_q == S_ISSUE) || (state_q == S_WAIT))
                         ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;

  assign resp_valid_o  = (state_q == S_RESP);
  assign resp_cause_o  = (state_q == S_RESP) ? cause_q : CAUSE_OK;
  assign resp_err_o    = (state_q == S_RESP) && (cause_q != CAUSE_OK);
  assign resp_rdata_o  = rdata_q;

endmodule

// File: tb/tb_lsu_dcache_port.sv
// Directed bench for lsu_dcache_port: store lane steering, load formatting,
// error responses, timeout and reset abandonment, with hand-computed expectations.
module tb_lsu_dcache_port;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [1:0]  resp_cause_o;
  logic [31:0] cache_addr_o;
  logic [31:0] cache_wdata_o;
  logic [3:0]  cache_wstrb_o;
  logic        cache_write_o;
  logic        cache_read_o;
  logic [31:0] cache_rdata_i;
  logic        cache_ready_i;

  int checks = 0;
  int errors = 0;

  lsu_dcache_port dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .resp_cause_o   (resp_cause_o),
    .cache_addr_o   (cache_addr_o),
    .cache_wdata_o  (cache_wdata_o),
    .cache_wstrb_o  (cache_wstrb_o),
    .cache_write_o  (cache_write_o),
    .cache_read_o   (cache_read_o),
    .cache_rdata_i  (cache_rdata_i),
    .cache_ready_i  (cache_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
  endtask

  // Full cache access: accept, one-cycle issue, wait_cycles extra WAIT cycles, ready, response.
  task automatic access(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        input int wait_cycles, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_wstrb, input logic [31:0] exp_rdata);
    check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    drive_req(we, size, uns, addr, wdata);
    step();
    req_valid_i = 1'b0;
    check({tag, "_wr"}, 32'(cache_write_o), 32'(we));
    check({tag, "_rd"}, 32'(cache_read_o), 32'(!we));
    check({tag, "_addr"}, cache_addr_o, addr & 32'hffff_fffc);
    check({tag, "_wstrb"}, 32'(cache_wstrb_o), 32'(exp_wstrb));
    check({tag, "_wdata"}, cache_wdata_o, exp_wdata);
    step();
    check({tag, "_pulse"}, 32'({cache_write_o, cache_read_o}), 32'd0);
    check({tag, "_wstrb0"}, 32'(cache_wstrb_o), 32'd0);
    check({tag, "_addr_hold"}, cache_addr_o, addr & 32'hffff_fffc);
    repeat (wait_cycles) step();
    check({tag, "_early"}, 32'(resp_valid_o), 32'd0);
    cache_ready_i = 1'b1;
    cache_rdata_i = rdata;
    step();
    cache_ready_i = 1'b0;
    cache_rdata_i = 32'h0bad_cafe;
    check({tag, "_rvalid"}, 32'(resp_valid_o), 32'd1);
    check({tag, "_err"}, 32'(resp_err_o), 32'd0);
    check({tag, "_cause"}, 32'(resp_cause_o), 32'd0);
    check({tag, "_rdata"}, resp_rdata_o, exp_rdata);
    step();
    check({tag, "_pulse1"}, 32'(resp_valid_o), 32'd0);
    check({tag, "_rhold"}, resp_rdata_o, exp_rdata);
  endtask

  // Request rejected without touching the cache: response in the very next cycle.
  task automatic bad_req(input string tag, input logic [1:0] size, input logic [31:0] addr,
                         input logic [1:0] exp_cause);
    check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    drive_req(1'b0, size, 1'b0, addr, 32'h0);
    step();
    req_valid_i = 1'b0;
    check({tag, "_rvalid"}, 32'(resp_valid_o), 32'd1);
    check({tag, "_cause"}, 32'(resp_cause_o), 32'(exp_cause));
    check({tag, "_err"}, 32'(resp_err_o), 32'd1);
    check({tag, "_noacc"}, 32'({cache_read_o, cache_write_o}), 32'd0);
    check({tag, "_rdata"}, resp_rdata_o, 32'd0);
    step();
    check({tag, "_pulse1"}, 32'(resp_valid_o), 32'd0);
  endtask

  initial begin
    int n;
    rst_n          = 1'b0;
    req_valid_i    = 1'b0;
    req_we_i       = 1'b0;
    req_size_i     = 2'b00;
    req_unsigned_i = 1'b0;
    req_addr_i     = '0;
    req_wdata_i    = '0;
    cache_rdata_i  = '0;
    cache_ready_i  = 1'b0;

    #2;
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_outs", 32'({resp_valid_o, resp_err_o, resp_cause_o, cache_write_o, cache_read_o}), 32'd0);
    check("rst_rdata", resp_rdata_o, 32'd0);
    check("rst_caddr", cache_addr_o, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_ready", 32'(req_ready_o), 32'd1);

    // Stores: lane replication and strobes.
    access("sw04", 1'b1, 2'b10, 1'b0, 32'h04, 32'ha5a5_a5a5, 32'h0, 0, 32'ha5a5_a5a5, 4'b1111, 32'h0);
    access("sb06", 1'b1, 2'b00, 1'b0, 32'h06, 32'h1234_565a, 32'h0, 1, 32'h5a5a_5a5a, 4'b0100, 32'h0);
    access("sh16", 1'b1, 2'b01, 1'b0, 32'h16, 32'hdead_1234, 32'h0, 0, 32'h1234_1234, 4'b1100, 32'h0);

    // Loads from a cache word of 0x80ff7f01.
    access("lb3",  1'b0, 2'b00, 1'b0, 32'h03, 32'h0, 32'h80ff_7f01, 2, 32'h0, 4'b0000, 32'hffff_ff80);
    access("lbu3", 1'b0, 2'b00, 1'b1, 32'h03, 32'h0, 32'h80ff_7f01, 0, 32'h0, 4'b0000, 32'h0000_0080);
    access("lh0",  1'b0, 2'b01, 1'b0, 32'h00, 32'h0, 32'h80ff_7f01, 0, 32'h0, 4'b0000, 32'h0000_7f01);
    access("lhu2", 1'b0, 2'b01, 1'b1, 32'h02, 32'h0, 32'h80ff_7f01, 0, 32'h0, 4'b0000, 32'h0000_80ff);
    access("lh2",  1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 32'h80ff_7f01, 0, 32'h0, 4'b0000, 32'hffff_80ff);
    access("lw8",  1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'hdead_beef, 3, 32'h0, 4'b0000, 32'hdead_beef);

    // Errors without cache access.
    bad_req("lw06_mis", 2'b10, 32'h06, 2'b01);
    access("lb1", 1'b0, 2'b00, 1'b0, 32'h01, 32'h0, 32'h0000_7f00, 0, 32'h0, 4'b0000, 32'h0000_007f);
    bad_req("sz11", 2'b11, 32'h00, 2'b10);
    bad_req("lh1_mis", 2'b01, 32'h01, 2'b01);

    // Timeout: cache never answers.
    check("to_ready", 32'(req_ready_o), 32'd1);
    drive_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    step();
    req_valid_i = 1'b0;
    check("to_issue", 32'(cache_read_o), 32'd1);
    step();
    n = 0;
    while (!resp_valid_o && n < 100) begin
      step();
      n++;
    end
    check("to_cycles", 32'(n), 32'd64);
    check("to_cause", 32'(resp_cause_o), 32'd3);
    check("to_err", 32'(resp_err_o), 32'd1);
    check("to_rdata", resp_rdata_o, 32'd0);
    step();
    cache_ready_i = 1'b1;
    cache_rdata_i = 32'h1111_1111;
    step();
    check("late_ready_rv", 32'(resp_valid_o), 32'd0);
    step();
    cache_ready_i = 1'b0;
    check("late_ready_idle", 32'(req_ready_o), 32'd1);
    check("late_ready_rv2", 32'(resp_valid_o), 32'd0);

    // Reset during WAIT abandons the request.
    drive_req(1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
    step();
    req_valid_i = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("wrst_ready", 32'(req_ready_o), 32'd0);
    check("wrst_rv", 32'(resp_valid_o), 32'd0);
    check("wrst_caddr", cache_addr_o, 32'd0);
    cache_ready_i = 1'b1;
    cache_rdata_i = 32'h2222_2222;
    step();
    rst_n = 1'b1;
    step();
    check("wrst_norsp", 32'(resp_valid_o), 32'd0);
    step();
    cache_ready_i = 1'b0;
    check("wrst_norsp2", 32'(resp_valid_o), 32'd0);
    check("wrst_rdata", resp_rdata_o, 32'd0);
    access("lw28", 1'b0, 2'b10, 1'b0, 32'h28, 32'h0, 32'h1357_9bdf, 1, 32'h0, 4'b0000, 32'h1357_9bdf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
